// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and default byte/requester sizing
// used by the TX arbiter and the TX/RX serializers.
package uart_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Producer/serializer port bundle of the UART TX arbiter.
// Optional req_lock signal exists only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arb_if #(
   parameter int N_REQ  = uart_pkg::N_REQ_DEF,
   parameter int DATA_W = uart_pkg::DATA_W_DEF
);
   localparam int ID_W = $clog2(N_REQ);

   // Handshake: a byte moves from requester i when req_valid[i] and req_ready[i]
   // are both high on a rising clk edge; req_ready is one-hot or zero.
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    tx_start;
   logic [DATA_W-1:0]       tx_data;
   logic                    tx_busy;
   logic                    tx_done;
   logic [ID_W-1:0]         grant_id;
   logic                    active;
`ifdef UART_ARB_LOCK_EN
   logic [N_REQ-1:0]        req_lock;

   modport master (
      input  req_valid, req_data, tx_busy, tx_done, req_lock,
      output req_ready, tx_start, tx_data, grant_id, active
   );
   modport slave (
      output req_valid, req_data, tx_busy, tx_done, req_lock,
      input  req_ready, tx_start, tx_data, grant_id, active
   );
`else
   modport master (
      input  req_valid, req_data, tx_busy, tx_done,
      output req_ready, tx_start, tx_data, grant_id, active
   );
   modport slave (
      output req_valid, req_data, tx_busy, tx_done,
      input  req_ready, tx_start, tx_data, grant_id, active
   );
`endif

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first masked request scanning upward from ptr+1.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (int'(ptr) + k) % N;
         if (!any && req[j] && mask[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX serializer among N_REQ byte producers.
// Optional UART_ARB_LOCK_EN keeps the grant with a requester across a multi-byte message.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_arb_if.master bus,
   output arb_state_e    dbg_state
);

   localparam int ID_W = $clog2(N_REQ);

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   ptr_q, grant_id_q, pick_ptr, pick_idx;
   logic [DATA_W-1:0] tx_data_q;
   logic [N_REQ-1:0]  pick_mask, pick_gnt, ready_d;
   logic              pick_any, accept, frame_done, tx_start_d, active_d;

   rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
      .req  (bus.req_valid),
      .mask (pick_mask),
      .ptr  (pick_ptr),
      .gnt  (pick_gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

`ifdef UART_ARB_LOCK_EN
   logic locked_q, lock_now;

   // While locked, only the owner is eligible and the scan restarts at the owner.
   assign lock_now  = bus.req_lock[grant_id_q];
   assign pick_mask = (locked_q && lock_now) ? (N_REQ'(1) << grant_id_q) : '1;
   assign pick_ptr  = locked_q ? grant_id_q : ptr_q;
`else
   assign pick_mask = '1;
   assign pick_ptr  = ptr_q;
`endif

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      frame_done = 1'b0;
      ready_d    = '0;
      tx_start_d = 1'b0;
      active_d   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (!reset && !bus.tx_busy && pick_any) begin
               accept  = 1'b1;
               ready_d = pick_gnt;
               state_d = ARB_START;
            end
         end
         ARB_START: begin
            tx_start_d = 1'b1;
            active_d   = 1'b1;
            state_d    = ARB_WAIT;
         end
         ARB_WAIT: begin
            active_d = 1'b1;
            if (bus.tx_done) begin
               frame_done = 1'b1;
               state_d    = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         ptr_q      <= ID_W'(N_REQ - 1);
         grant_id_q <= '0;
         tx_data_q  <= '0;
`ifdef UART_ARB_LOCK_EN
         locked_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            tx_data_q  <= bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
            grant_id_q <= pick_idx;
         end
`ifdef UART_ARB_LOCK_EN
         if (frame_done) begin
            if (lock_now) begin
               locked_q <= 1'b1;
            end else begin
               locked_q <= 1'b0;
               ptr_q    <= grant_id_q;
            end
         end else if (state_q == ARB_IDLE && locked_q && !lock_now) begin
            // Release: round-robin resumes after the former owner.
            locked_q <= 1'b0;
            ptr_q    <= grant_id_q;
         end
`else
         if (frame_done) ptr_q <= grant_id_q;
`endif
      end
   end

   assign bus.req_ready = ready_d;
   assign bus.tx_start  = tx_start_d;
   assign bus.active    = active_d;
   assign bus.tx_data   = tx_data_q;
   assign bus.grant_id  = grant_id_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-cycle vector table plus serializer-model streams.
// The lock stream is compiled only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arb;
   import uart_pkg::*;

   localparam int N = 4;
   localparam int W = 8;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        busy;
      logic        done;
      logic [3:0]  e_ready;
      logic        e_start;
      logic [7:0]  e_data;
      logic [1:0]  e_gid;
      logic        e_active;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   arb_state_e dbg_state;

   uart_tx_arb_if #(.N_REQ(N), .DATA_W(W)) bus ();

   uart_tx_arb #(.N_REQ(N), .DATA_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   vec_t       vt[22];
   logic [7:0] exp_q[$];
   logic [1:0] exp_gid_q[$];
   logic [7:0] src_data[4][4];
   int         src_cnt[4];
   int         src_pos[4];
   int         src_start[4];
   logic [3:0] src_lock;

   function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic b, logic dn,
                               logic [3:0] er, logic es, logic [7:0] ed, logic [1:0] eg,
                               logic ea);
      vec_t x;
      x.rst = r; x.valid = v; x.data = d; x.busy = b; x.done = dn;
      x.e_ready = er; x.e_start = es; x.e_data = ed; x.e_gid = eg; x.e_active = ea;
      return x;
   endfunction

   function void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endfunction

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_busy   = 1'b0;
      bus.tx_done   = 1'b0;
`ifdef UART_ARB_LOCK_EN
      bus.req_lock  = '0;
`endif
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic apply_vec(input int k);
      @(posedge clk); #1;
      reset         = vt[k].rst;
      bus.req_valid = vt[k].valid;
      bus.req_data  = vt[k].data;
      bus.tx_busy   = vt[k].busy;
      bus.tx_done   = vt[k].done;
      @(negedge clk);
      chk($sformatf("v%0d req_ready", k), 32'(bus.req_ready), 32'(vt[k].e_ready));
      chk($sformatf("v%0d tx_start", k),  32'(bus.tx_start),  32'(vt[k].e_start));
      chk($sformatf("v%0d tx_data", k),   32'(bus.tx_data),   32'(vt[k].e_data));
      chk($sformatf("v%0d grant_id", k),  32'(bus.grant_id),  32'(vt[k].e_gid));
      chk($sformatf("v%0d active", k),    32'(bus.active),    32'(vt[k].e_active));
   endtask

   // Serializer model: tx_done five cycles after each tx_start, busy in between.
   task automatic run_stream(input string tag, input int budget);
      int         ser_cnt;
      bit         fin;
      logic [7:0] e_d;
      logic [1:0] e_g;
      ser_cnt = -1;
      fin     = 1'b0;
      for (int cyc = 0; cyc < budget && !fin; cyc++) begin
         @(posedge clk); #1;
         if (ser_cnt >= 0) ser_cnt++;
         if (ser_cnt == 6) ser_cnt = -1;
         bus.tx_busy = (ser_cnt >= 1);
         bus.tx_done = (ser_cnt == 5);
         for (int i = 0; i < N; i++) begin
            bus.req_valid[i]       = (cyc >= src_start[i]) && (src_pos[i] < src_cnt[i]);
            bus.req_data[i*W +: W] = src_data[i][(src_pos[i] < 4) ? src_pos[i] : 3];
`ifdef UART_ARB_LOCK_EN
            bus.req_lock[i]        = src_lock[i] && (src_pos[i] < src_cnt[i]);
`endif
         end
         @(negedge clk);
         if (bus.tx_start) begin
            ser_cnt = 0;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL %s extra frame: got data %h, required no frame", tag, bus.tx_data);
            end else begin
               e_d = exp_q.pop_front();
               e_g = exp_gid_q.pop_front();
               chk($sformatf("%s frame data", tag), 32'(bus.tx_data), 32'(e_d));
               chk($sformatf("%s frame grant", tag), 32'(bus.grant_id), 32'(e_g));
            end
         end
         for (int i = 0; i < N; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) src_pos[i]++;
         if (exp_q.size() == 0 && ser_cnt < 0 && !bus.active && bus.req_ready == '0) fin = 1'b1;
      end
      if (!fin) begin
         n_vec++;
         n_err++;
         $display("FAIL %s timeout: got %0d frames pending, required 0", tag, exp_q.size());
      end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Single request, busy hold-off, tx_done in IDLE and in START.
      vt[0]  = mk(0, 4'b0001, 32'h0000_00A5, 0, 0, 4'b0001, 0, 8'h00, 0, 0);
      vt[1]  = mk(0, 4'b0000, 32'h0,         0, 0, 4'b0000, 1, 8'hA5, 0, 1);
      vt[2]  = mk(0, 4'b0000, 32'h0,         1, 0, 4'b0000, 0, 8'hA5, 0, 1);
      vt[3]  = mk(0, 4'b0000, 32'h0,         1, 1, 4'b0000, 0, 8'hA5, 0, 1);
      vt[4]  = mk(0, 4'b0000, 32'h0,         0, 0, 4'b0000, 0, 8'hA5, 0, 0);
      vt[5]  = mk(0, 4'b0000, 32'h0,         0, 1, 4'b0000, 0, 8'hA5, 0, 0);
      vt[6]  = mk(0, 4'b0000, 32'h0,         0, 0, 4'b0000, 0, 8'hA5, 0, 0);
      vt[7]  = mk(0, 4'b0010, 32'h0000_3C00, 1, 0, 4'b0000, 0, 8'hA5, 0, 0);
      vt[8]  = mk(0, 4'b0010, 32'h0000_3C00, 1, 0, 4'b0000, 0, 8'hA5, 0, 0);
      vt[9]  = mk(0, 4'b0010, 32'h0000_3C00, 0, 0, 4'b0010, 0, 8'hA5, 0, 0);
      vt[10] = mk(0, 4'b0000, 32'h0,         0, 1, 4'b0000, 1, 8'h3C, 1, 1);
      vt[11] = mk(0, 4'b0000, 32'h0,         1, 0, 4'b0000, 0, 8'h3C, 1, 1);
      vt[12] = mk(0, 4'b0000, 32'h0,         1, 1, 4'b0000, 0, 8'h3C, 1, 1);
      vt[13] = mk(0, 4'b0000, 32'h0,         0, 0, 4'b0000, 0, 8'h3C, 1, 0);
      // Reset while in WAIT, then requester 0 must win over requester 2.
      vt[14] = mk(0, 4'b0100, 32'h005E_0000, 0, 0, 4'b0100, 0, 8'h10, 0, 0);
      vt[15] = mk(0, 4'b0000, 32'h0,         0, 0, 4'b0000, 1, 8'h5E, 2, 1);
      vt[16] = mk(1, 4'b0000, 32'h0,         1, 0, 4'b0000, 0, 8'h5E, 2, 1);
      vt[17] = mk(0, 4'b0000, 32'h0,         0, 0, 4'b0000, 0, 8'h00, 0, 0);
      vt[18] = mk(0, 4'b0101, 32'h00EF_00AB, 0, 0, 4'b0001, 0, 8'h00, 0, 0);
      vt[19] = mk(0, 4'b0000, 32'h0,         0, 0, 4'b0000, 1, 8'hAB, 0, 1);
      vt[20] = mk(0, 4'b0000, 32'h0,         1, 1, 4'b0000, 0, 8'hAB, 0, 1);
      vt[21] = mk(0, 4'b0000, 32'h0,         0, 0, 4'b0000, 0, 8'hAB, 0, 0);

      reset = 1'b1;
      clear_inputs();
      do_reset();
      @(negedge clk);
      chk("reset req_ready", 32'(bus.req_ready), 32'h0);
      chk("reset tx_start",  32'(bus.tx_start),  32'h0);
      chk("reset tx_data",   32'(bus.tx_data),   32'h0);
      chk("reset grant_id",  32'(bus.grant_id),  32'h0);
      chk("reset active",    32'(bus.active),    32'h0);
      chk("reset state",     32'(dbg_state),     32'(ARB_IDLE));

      for (int k = 0; k <= 13; k++) apply_vec(k);

      // All four requesters valid: rotation 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < N; i++) begin
         src_cnt[i] = 1; src_pos[i] = 0; src_start[i] = 0;
         for (int j = 0; j < 4; j++) src_data[i][j] = 8'h10 + 8'(i);
      end
      src_cnt[0] = 2;
      src_lock   = 4'b0000;
      exp_q      = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      exp_gid_q  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      run_stream("rr", 400);

      for (int k = 14; k <= 21; k++) apply_vec(k);

`ifdef UART_ARB_LOCK_EN
      // Requester 2 locks three bytes while requester 1 waits.
      do_reset();
      for (int i = 0; i < N; i++) begin
         src_cnt[i] = 0; src_pos[i] = 0; src_start[i] = 0;
         for (int j = 0; j < 4; j++) src_data[i][j] = 8'h00;
      end
      src_cnt[2] = 3;
      src_data[2][0] = 8'hC0; src_data[2][1] = 8'hC1; src_data[2][2] = 8'hC2;
      src_cnt[1] = 1; src_start[1] = 2;
      src_data[1][0] = 8'h77;
      src_lock  = 4'b0100;
      exp_q     = '{8'hC0, 8'hC1, 8'hC2, 8'h77};
      exp_gid_q = '{2'd2, 2'd2, 2'd2, 2'd1};
      run_stream("lock", 400);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
